// File: rtl/flag_arb_pkg.sv
// +----------------------------------------------------------------------+
// | flag_arb_pkg : shared state encoding for the flag ownership arbiter   |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package flag_arb_pkg;

   localparam int c_state_w = 3;

   typedef enum logic [c_state_w-1:0] {
      IDLE     = 3'd0,
      SET      = 3'd1,
      OWNED    = 3'd2,
      CLR      = 3'd3,
      WAIT_LOW = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// +----------------------------------------------------------------------+
// | rr_pick  : combinational round-robin picker starting at ptr           |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic               any_req,
   output logic [ID_W-1:0]    winner
);

   localparam logic [ID_W:0] c_num = (ID_W+1)'(NUM_REQ);

   logic [2*NUM_REQ-1:0] w_dbl;
   logic [ID_W:0]        w_idx;
   logic [ID_W:0]        w_wrap;

   assign w_dbl = {req, req};

   // Scan downward so the candidate nearest ptr is the last one written.
   always_comb begin
      any_req = 1'b0;
      winner  = '0;
      w_idx   = '0;
      w_wrap  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         w_idx = {1'b0, ptr} + (ID_W+1)'(i);
         if (w_dbl[w_idx]) begin
            any_req = 1'b1;
            w_wrap  = (w_idx >= c_num) ? (w_idx - c_num) : w_idx;
            winner  = w_wrap[ID_W-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/flag_owner_arbiter.sv
// +----------------------------------------------------------------------+
// | flag_owner_arbiter : round-robin owner of a shared set/clear flag,    |
// |                      with optional hold timeout                       |
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module flag_owner_arbiter
   import flag_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int HOLD_MAX = 255,
   parameter int CNT_W    = 8,
   parameter int ID_W     = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] rel,
   input  logic               flag_i,
   output logic               set_o,
   output logic               clr_o,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    owner_id,
   output logic               busy,
   output logic               timeout_o
);

   localparam logic [CNT_W-1:0] c_hold_last =
      CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
   localparam bit               c_timeout_en = (HOLD_MAX != 0);
   localparam logic [ID_W-1:0]  c_last_id    = ID_W'(NUM_REQ - 1);

   state_t             r_state;
   logic [ID_W-1:0]    r_ptr;
   logic [CNT_W-1:0]   r_hold_cnt;

   logic               w_any_req;
   logic [ID_W-1:0]    w_winner;
   logic [ID_W-1:0]    w_ptr_next;
   logic               w_rel_own;
   logic               w_hold_hit;
   logic [NUM_REQ-1:0] w_owner_oh;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req     (req),
      .ptr     (r_ptr),
      .any_req (w_any_req),
      .winner  (w_winner)
   );

   assign w_ptr_next = (w_winner == c_last_id) ? '0 : w_winner + 1'b1;
   assign w_rel_own  = rel[owner_id];
   assign w_hold_hit = c_timeout_en && (r_hold_cnt == c_hold_last);
   assign w_owner_oh = NUM_REQ'(1) << owner_id;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_hold_cnt <= '0;
         owner_id   <= '0;
         set_o      <= 1'b0;
         clr_o      <= 1'b0;
         gnt        <= '0;
         busy       <= 1'b0;
         timeout_o  <= 1'b0;
      end else begin
         set_o     <= 1'b0;
         clr_o     <= 1'b0;
         timeout_o <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  owner_id <= w_winner;
                  r_ptr    <= w_ptr_next;
                  set_o    <= 1'b1;
                  busy     <= 1'b1;
                  r_state  <= SET;
               end
            end
            SET: begin
               r_hold_cnt <= '0;
               gnt        <= w_owner_oh;
               r_state    <= OWNED;
            end
            OWNED: begin
               if (r_hold_cnt != '1) begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
               // An owner release takes precedence over a coincident timeout.
               if (w_rel_own) begin
                  gnt     <= '0;
                  clr_o   <= 1'b1;
                  r_state <= CLR;
               end else if (w_hold_hit) begin
                  gnt       <= '0;
                  clr_o     <= 1'b1;
                  timeout_o <= 1'b1;
                  r_state   <= CLR;
               end
            end
            CLR: begin
               r_state <= WAIT_LOW;
            end
            WAIT_LOW: begin
               if (!flag_i) begin
                  busy    <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               gnt     <= '0;
               busy    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_flag_owner_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_flag_owner_arbiter : directed bench for flag_owner_arbiter         |
// | Revision              : 1.0                                           |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_flag_owner_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic [3:0] req_a = '0, rel_a = '0, req_b = '0, rel_b = '0;
   logic       force_a = 1'b0, force_b = 1'b0;

   logic       set_a, clr_a, busy_a, to_a, flag_a;
   logic [3:0] gnt_a;
   logic [1:0] own_a;
   logic       set_b, clr_b, busy_b, to_b, flag_b;
   logic [3:0] gnt_b;
   logic [1:0] own_b;

   logic       fa, cda, fb, cdb;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Instance a never times out; instance b forces release after 8 cycles.
   flag_owner_arbiter #(.NUM_REQ(4), .HOLD_MAX(0), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .req(req_a), .rel(rel_a), .flag_i(flag_a),
      .set_o(set_a), .clr_o(clr_a), .gnt(gnt_a), .owner_id(own_a),
      .busy(busy_a), .timeout_o(to_a)
   );

   flag_owner_arbiter #(.NUM_REQ(4), .HOLD_MAX(8), .CNT_W(8)) dut_b (
      .clk(clk), .rst(rst), .req(req_b), .rel(rel_b), .flag_i(flag_b),
      .set_o(set_b), .clr_o(clr_b), .gnt(gnt_b), .owner_id(own_b),
      .busy(busy_b), .timeout_o(to_b)
   );

   // Downstream set/clear flag: set next cycle, clear delayed by one more.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fa <= 1'b0; cda <= 1'b0; fb <= 1'b0; cdb <= 1'b0;
      end else begin
         cda <= clr_a;
         cdb <= clr_b;
         if (set_a) fa <= 1'b1; else if (cda) fa <= 1'b0;
         if (set_b) fb <= 1'b1; else if (cdb) fb <= 1'b0;
      end
   end

   assign flag_a = fa | force_a;
   assign flag_b = fb | force_b;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_a = '0; rel_a = '0; req_b = '0; rel_b = '0;
      force_a = 1'b0; force_b = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy_a || busy_b) && n < 40) begin
         tick();
         n++;
      end
      check("idle_reached", {31'd0, busy_a | busy_b}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int clr_seen;
      logic [3:0] exp;

      // Reset values
      do_reset();
      check("rst_a", {gnt_a, own_a, busy_a, set_a, clr_a, to_a}, 32'd0);
      check("rst_b", {gnt_b, own_b, busy_b, set_b, clr_b, to_b}, 32'd0);

      // Single requester 2, rel in cycle 10
      req_a = 4'b0100;
      tick();
      check("t1_set_c1", set_a, 1);
      check("t1_gnt_c1", gnt_a, 0);
      tick();
      for (int c = 2; c <= 10; c++) begin
         check("t1_gnt", gnt_a, 4'b0100);
         check("t1_set_low", set_a, 0);
         if (c == 10) begin
            rel_a = 4'b0100;
            req_a = '0;
         end
         tick();
      end
      rel_a = '0;
      check("t1_clr_c11", clr_a, 1);
      check("t1_gnt_c11", gnt_a, 0);
      check("t1_owner", own_a, 2);
      tick();
      check("t1_clr_c12", clr_a, 0);
      tick();
      check("t1_busy_c13", busy_a, 1);
      tick();
      check("t1_busy_c14", busy_a, 0);
      check("t1_owner_kept", own_a, 2);

      // HOLD_MAX=0: ownership never expires
      req_a = 4'b0001;
      tick();
      tick();
      clr_seen = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (clr_a || to_a) clr_seen++;
      end
      check("hold0_gnt", gnt_a, 4'b0001);
      check("hold0_noclr", clr_seen, 0);
      rel_a = 4'b0001;
      req_a = '0;
      tick();
      rel_a = '0;
      wait_idle();

      // Round-robin with all four requests held
      do_reset();
      req_a = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         n = 0;
         while (gnt_a == '0 && n < 20) begin
            tick();
            n++;
         end
         exp = 4'b0001 << (g % 4);
         check("rr_gap", n, (g == 0) ? 2 : 5);
         check("rr_gnt", gnt_a, exp);
         check("rr_owner", own_a, g % 4);
         for (int k = 1; k <= 3; k++) begin
            tick();
            check("rr_hold", gnt_a, exp);
         end
         rel_a = exp;
         tick();
         rel_a = '0;
         check("rr_clr", clr_a, 1);
         check("rr_gnt_drop", gnt_a, 0);
      end
      req_a = '0;
      wait_idle();

      // Flag held high 5 extra cycles after clr_o
      req_a = 4'b0010;
      tick();
      tick();
      check("wl_gnt", gnt_a, 4'b0010);
      rel_a = 4'b0010;
      tick();
      rel_a = '0;
      force_a = 1'b1;
      check("wl_clr", clr_a, 1);
      for (int i = 1; i <= 6; i++) begin
         tick();
         check("wl_busy", busy_a, 1);
         check("wl_noset", set_a, 0);
      end
      force_a = 1'b0;
      tick();
      check("wl_idle", busy_a, 0);
      check("wl_idle_noset", set_a, 0);
      tick();
      check("wl_set", set_a, 1);
      check("wl_owner", own_a, 1);
      req_a = '0;
      tick();
      rel_a = 4'b0010;
      tick();
      rel_a = '0;
      wait_idle();

      // Non-owner rel ignored, then reset mid-ownership
      do_reset();
      req_a = 4'b1000;
      tick();
      tick();
      check("rs_owner3", own_a, 3);
      tick();
      rel_a = 4'b0010;
      tick();
      rel_a = '0;
      check("rs_nonowner_gnt", gnt_a, 4'b1000);
      check("rs_nonowner_clr", clr_a, 0);
      rst = 1'b1;
      #1;
      check("rs_async", {gnt_a, busy_a, set_a, clr_a}, 32'd0);
      tick();
      check("rs_held", {gnt_a, own_a, busy_a, set_a, clr_a, to_a}, 32'd0);
      rst = 1'b0;
      req_a = 4'b0001;
      check("rs_release", {gnt_a, own_a, busy_a, set_a, clr_a, to_a}, 32'd0);
      tick();
      check("rs_set", set_a, 1);
      check("rs_owner0", own_a, 0);
      req_a = '0;
      tick();
      rel_a = 4'b0001;
      tick();
      rel_a = '0;
      wait_idle();

      // Timeout with HOLD_MAX=8
      req_b = 4'b0001;
      tick();
      tick();
      for (int c = 2; c <= 9; c++) begin
         check("to_gnt", gnt_b, 4'b0001);
         check("to_early", {to_b, clr_b}, 0);
         tick();
      end
      req_b = '0;
      check("to_pulse", to_b, 1);
      check("to_clr", clr_b, 1);
      check("to_gnt_drop", gnt_b, 0);
      tick();
      check("to_pulse_end", {to_b, clr_b}, 0);
      wait_idle();

      // rel coincident with the timeout cycle
      req_b = 4'b0010;
      tick();
      tick();
      for (int i = 0; i < 7; i++) tick();
      check("co_gnt_c9", gnt_b, 4'b0010);
      rel_b = 4'b0010;
      req_b = '0;
      tick();
      rel_b = '0;
      check("co_clr", clr_b, 1);
      check("co_no_timeout", to_b, 0);
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
